// File: rtl/if_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
// Provides NOP encoding, fetch FSM states, IF/ID bundle and default reset PC.
package if_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        pc:    32'h0,
        pc4:   32'h0,
        instr: NOP_INSTR,
        valid: 1'b0
    };

endpackage

// File: rtl/ifid_perf_cnt.sv
// Fetch-stage event counters: hold cycles and redirects, both wrapping at 2^32.
// Ports: clk, rst_n (sync, active low), stall_ev, flush_ev -> stall_cycles, flush_count.
module ifid_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_ev,
    input  logic        flush_ev,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
        end else begin
            if (stall_ev) stall_cycles <= stall_cycles + 32'd1;
            if (flush_ev) flush_count  <= flush_count + 32'd1;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// PC register, next-PC select, IF/ID register, fetch FSM and stall watchdog.
// Ports: clk, rst_n (sync, active low); HDU stall_i/pc_ifwrite_i; ID redirects
//   jump_i/branch_taken_i + targets; imem_instr_i -> imem_addr_o, IF/ID outputs
//   (pc_id_o, pc4_id_o, instr_id_o, valid_id_o), stall_timeout_o, perf counters.
// Macro IF_PERF_CNT_EN enables stall_cycles_o / flush_count_o; otherwise tied to 0.
module if_id_pipe
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          MAX_STALL = 16,
    parameter int          CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        pc_ifwrite_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc4_id_o,
    output logic [31:0] instr_id_o,
    output logic        valid_id_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    logic [31:0]      pc_q, pc_d, pc_plus4, redir_tgt;
    if_id_t           ifid_q, ifid_d;
    if_state_e        state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             tmo_q, tmo_d;
    logic             hold, redirect;

    assign hold     = stall_i | ~pc_ifwrite_i;
    assign redirect = (jump_i | branch_taken_i) & ~hold;
    assign pc_plus4 = pc_q + 32'd4;
    // Jump has priority; targets are forced word-aligned.
    assign redir_tgt = (jump_i ? jump_target_i : branch_target_i)
                     & 32'hFFFF_FFFC;

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        scnt_d = '0;
        tmo_d  = tmo_q;
        unique case (1'b1)
            hold: begin
                if (scnt_q != MAX_CNT) scnt_d = scnt_q + 1'b1;
                else                   scnt_d = scnt_q;
                // Trips on the edge where the count reaches MAX_STALL.
                if (scnt_q >= MAX_CNT - 1'b1) tmo_d = 1'b1;
            end
            redirect: begin
                pc_d   = redir_tgt;
                ifid_d = IF_ID_BUBBLE;
            end
            default: begin
                pc_d         = pc_plus4;
                ifid_d.pc    = pc_q;
                ifid_d.pc4   = pc_plus4;
                ifid_d.instr = imem_instr_i;
                ifid_d.valid = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = RUN;
        if (hold)          state_d = HOLD;
        else if (redirect) state_d = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ifid_q  <= IF_ID_BUBBLE;
            state_q <= RUN;
            scnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign imem_addr_o     = pc_q;
    assign pc_id_o         = ifid_q.pc;
    assign pc4_id_o        = ifid_q.pc4;
    assign instr_id_o      = ifid_q.instr;
    assign valid_id_o      = ifid_q.valid & (state_q != FLUSH);
    assign stall_timeout_o = tmo_q;

`ifdef IF_PERF_CNT_EN
    ifid_perf_cnt u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_ev     (hold),
        .flush_ev     (redirect),
        .stall_cycles (stall_cycles_o),
        .flush_count  (flush_count_o)
    );
`else
    assign stall_cycles_o = 32'h0;
    assign flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed-vector bench for if_id_pipe: free-run, stalls, redirects,
// watchdog, reset mid-flush and PC wrap from a high reset address.
module tb_if_id_pipe;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, pc_ifwrite_i, jump_i, branch_taken_i;
    logic [31:0] jump_target_i, branch_target_i;
    logic [31:0] imem_instr, imem_addr, pc_id, pc4_id, instr_id;
    logic        valid_id, tmo;
    logic [31:0] stall_cycles, flush_count;

    logic [31:0] w_instr, w_addr, w_pc_id, w_pc4_id, w_instr_id;
    logic        w_valid, w_tmo;
    logic [31:0] w_sc, w_fc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr | 32'hA000_0000;
    assign w_instr    = w_addr | 32'hA000_0000;

    if_id_pipe u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .pc_ifwrite_i    (pc_ifwrite_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_instr_i    (imem_instr),
        .imem_addr_o     (imem_addr),
        .pc_id_o         (pc_id),
        .pc4_id_o        (pc4_id),
        .instr_id_o      (instr_id),
        .valid_id_o      (valid_id),
        .stall_timeout_o (tmo),
        .stall_cycles_o  (stall_cycles),
        .flush_count_o   (flush_count)
    );

    if_id_pipe #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (1'b0),
        .pc_ifwrite_i    (1'b1),
        .jump_i          (1'b0),
        .jump_target_i   (32'h0),
        .branch_taken_i  (1'b0),
        .branch_target_i (32'h0),
        .imem_instr_i    (w_instr),
        .imem_addr_o     (w_addr),
        .pc_id_o         (w_pc_id),
        .pc4_id_o        (w_pc4_id),
        .instr_id_o      (w_instr_id),
        .valid_id_o      (w_valid),
        .stall_timeout_o (w_tmo),
        .stall_cycles_o  (w_sc),
        .flush_count_o   (w_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i         = 1'b0;
        pc_ifwrite_i    = 1'b1;
        jump_i          = 1'b0;
        branch_taken_i  = 1'b0;
        jump_target_i   = 32'h0;
        branch_target_i = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        n_vec++;
        if (imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pc got %h want 0", imem_addr);
        end
        n_vec++;
        if ({valid_id, pc_id, pc4_id, instr_id} !== 97'h0) begin
            n_err++;
            $display("FAIL reset_ifid got %b %h %h %h want 0",
                     valid_id, pc_id, pc4_id, instr_id);
        end
        n_vec++;
        if ({tmo, stall_cycles, flush_count} !== 65'h0) begin
            n_err++;
            $display("FAIL reset_misc got %b %h %h want 0",
                     tmo, stall_cycles, flush_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] ea;
        for (int k = 1; k <= 4; k++) begin
            tick();
            ea = 32'(k * 4);
            n_vec++;
            if (imem_addr !== ea || instr_id !== (32'hA000_0000 | (ea - 4))
                || pc_id !== ea - 4 || pc4_id !== ea || valid_id !== 1'b1) begin
                n_err++;
                $display("FAIL free_run%0d got %h %h %h %h %b want %h %h %h %h 1",
                         k, imem_addr, instr_id, pc_id, pc4_id, valid_id,
                         ea, 32'hA000_0000 | (ea - 4), ea - 4, ea);
            end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (imem_addr !== 32'h10 || instr_id !== 32'hA000_000C
                || pc_id !== 32'hC || valid_id !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d got %h %h %h %b want 10 a000000c c 1",
                         k, imem_addr, instr_id, pc_id, valid_id);
            end
        end
        stall_i = 1'b0;
        tick();
        n_vec++;
        if (imem_addr !== 32'h14 || instr_id !== 32'hA000_0010) begin
            n_err++;
            $display("FAIL stall_resume got %h %h want 14 a0000010",
                     imem_addr, instr_id);
        end
        n_vec++;
        if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
            n_err++;
            $display("FAIL stall_cycles got %0d want %0d",
                     stall_cycles, PERF ? 3 : 0);
        end
    endtask

    task automatic test_pc_ifwrite();
        pc_ifwrite_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (imem_addr !== 32'h14 || instr_id !== 32'hA000_0010
                || valid_id !== 1'b1) begin
                n_err++;
                $display("FAIL pcwr_hold%0d got %h %h %b want 14 a0000010 1",
                         k, imem_addr, instr_id, valid_id);
            end
        end
        pc_ifwrite_i = 1'b1;
        tick();
        tick();
        tick();
        n_vec++;
        if (imem_addr !== 32'h20 || instr_id !== 32'hA000_001C
            || stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin
            n_err++;
            $display("FAIL pcwr_resume got %h %h %0d want 20 a000001c %0d",
                     imem_addr, instr_id, stall_cycles, PERF ? 5 : 0);
        end
    endtask

    task automatic test_branch();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h103;
        tick();
        idle();
        n_vec++;
        if (imem_addr !== 32'h100 || valid_id !== 1'b0 || instr_id !== 32'h0
            || pc_id !== 32'h0 || pc4_id !== 32'h0) begin
            n_err++;
            $display("FAIL branch got %h %b %h %h %h want 100 0 0 0 0",
                     imem_addr, valid_id, instr_id, pc_id, pc4_id);
        end
        n_vec++;
        if (flush_count !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL flush_count got %0d want %0d",
                     flush_count, PERF ? 1 : 0);
        end
        tick();
        n_vec++;
        if (imem_addr !== 32'h104 || instr_id !== 32'hA000_0100
            || pc_id !== 32'h100 || valid_id !== 1'b1) begin
            n_err++;
            $display("FAIL branch_after got %h %h %h %b want 104 a0000100 100 1",
                     imem_addr, instr_id, pc_id, valid_id);
        end
    endtask

    task automatic test_back_to_back();
        stall_i         = 1'b1;
        jump_i          = 1'b1;
        jump_target_i   = 32'h200;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h300;
        tick();
        n_vec++;
        if (imem_addr !== 32'h104 || instr_id !== 32'hA000_0100
            || valid_id !== 1'b1 || flush_count !== (PERF ? 32'd1 : 32'd0)) begin
            n_err++;
            $display("FAIL redirect_in_stall got %h %h %b %0d want 104 a0000100 1",
                     imem_addr, instr_id, valid_id, flush_count);
        end
        stall_i = 1'b0;
        tick();
        n_vec++;
        if (imem_addr !== 32'h200 || valid_id !== 1'b0) begin
            n_err++;
            $display("FAIL jump_wins got %h %b want 200 0", imem_addr, valid_id);
        end
        jump_i          = 1'b0;
        branch_target_i = 32'h40;
        tick();
        branch_target_i = 32'h82;
        tick();
        idle();
        n_vec++;
        if (imem_addr !== 32'h80 || valid_id !== 1'b0
            || flush_count !== (PERF ? 32'd4 : 32'd0)) begin
            n_err++;
            $display("FAIL b2b_flush got %h %b %0d want 80 0 %0d",
                     imem_addr, valid_id, flush_count, PERF ? 4 : 0);
        end
        tick();
        n_vec++;
        if (imem_addr !== 32'h84 || instr_id !== 32'hA000_0080
            || valid_id !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_after got %h %h %b want 84 a0000080 1",
                     imem_addr, instr_id, valid_id);
        end
    endtask

    task automatic test_timeout();
        stall_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_vec++;
            if (tmo !== (k == 16)) begin
                n_err++;
                $display("FAIL timeout_edge%0d got %b want %b", k, tmo, k == 16);
            end
        end
        stall_i = 1'b0;
        tick();
        tick();
        n_vec++;
        if (tmo !== 1'b1 || imem_addr !== 32'h8C) begin
            n_err++;
            $display("FAIL timeout_sticky got %b %h want 1 8c", tmo, imem_addr);
        end
        n_vec++;
        if (stall_cycles !== (PERF ? 32'd22 : 32'd0)) begin
            n_err++;
            $display("FAIL stall_total got %0d want %0d",
                     stall_cycles, PERF ? 22 : 0);
        end
    endtask

    task automatic test_reset_mid_flush();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h500;
        tick();
        jump_i        = 1'b1;
        jump_target_i = 32'h600;
        rst_n         = 1'b0;
        tick();
        idle();
        n_vec++;
        if (imem_addr !== 32'h0 || valid_id !== 1'b0 || pc_id !== 32'h0
            || pc4_id !== 32'h0 || instr_id !== 32'h0) begin
            n_err++;
            $display("FAIL rst_flush_ifid got %h %b %h %h %h want 0",
                     imem_addr, valid_id, pc_id, pc4_id, instr_id);
        end
        n_vec++;
        if ({tmo, stall_cycles, flush_count} !== 65'h0) begin
            n_err++;
            $display("FAIL rst_flush_misc got %b %0d %0d want 0",
                     tmo, stall_cycles, flush_count);
        end
        n_vec++;
        if (w_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_reset got %h want fffffffc", w_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        tick();
        n_vec++;
        if (w_addr !== 32'h0 || w_pc_id !== 32'hFFFF_FFFC || w_pc4_id !== 32'h0
            || w_instr_id !== 32'hFFFF_FFFC || w_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap got %h %h %h %h %b want 0 fffffffc 0 fffffffc 1",
                     w_addr, w_pc_id, w_pc4_id, w_instr_id, w_valid);
        end
        n_vec++;
        if (imem_addr !== 32'h4 || instr_id !== 32'hA000_0000) begin
            n_err++;
            $display("FAIL post_reset_run got %h %h want 4 a0000000",
                     imem_addr, instr_id);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_pc_ifwrite();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
